// File: rtl/ocl_tile_slave.sv
// OCL tile slave: bridges one OCL AXI-Lite-style access at a time onto a bank of
// simple valid/ack register clients, with ack timeout and a saturating error count.
module ocl_tile_slave #(
    parameter int N_CLIENTS = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        awvalid,
    output logic                        awready,
    input  logic [31:0]                 awaddr,
    input  logic                        wvalid,
    output logic                        wready,
    input  logic [31:0]                 wdata,
    output logic                        bvalid,
    input  logic                        bready,
    input  logic                        arvalid,
    output logic                        arready,
    input  logic [31:0]                 araddr,
    output logic                        rvalid,
    input  logic                        rready,
    output logic [31:0]                 rdata,
    output logic [N_CLIENTS-1:0]        reg_wvalid,
    input  logic [N_CLIENTS-1:0]        reg_wack,
    output logic [7:0]                  reg_waddr,
    output logic [31:0]                 reg_wdata,
    output logic [N_CLIENTS-1:0]        reg_rvalid,
    input  logic [N_CLIENTS-1:0]        reg_rack,
    output logic [7:0]                  reg_raddr,
    input  logic [N_CLIENTS-1:0][31:0]  reg_rdata,
    output logic [15:0]                 err_count
);

    typedef enum logic [2:0] {
        IDLE, W_DATA, W_REQ, W_RESP, R_REQ, R_RESP
    } state_t;

    localparam logic [8:0]  NC        = 9'(N_CLIENTS);
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [7:0]  id;
    logic [15:0] wait_cnt;
    logic        wack_hit, rack_hit, waiting, timeout, err_inc;
    logic        id_bad, ar_bad;
    logic [31:0] sel_rdata;

    assign id_bad = ({1'b0, id} >= NC);
    assign ar_bad = ({1'b0, araddr[15:8]} >= NC);

    // Only the latched client sees a request strobe; an out-of-range id matches nothing.
    always_comb begin
        reg_wvalid = '0;
        reg_rvalid = '0;
        sel_rdata  = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (id == 8'(i)) begin
                reg_wvalid[i] = (state == W_REQ);
                reg_rvalid[i] = (state == R_REQ);
                sel_rdata     = reg_rdata[i];
            end
        end
    end

    assign wack_hit = |(reg_wack & reg_wvalid);
    assign rack_hit = |(reg_rack & reg_rvalid);
    assign waiting  = ((state == W_REQ) && !wack_hit) || ((state == R_REQ) && !rack_hit);
    assign timeout  = waiting && (wait_cnt == WAIT_LAST);

    assign awready = (state == IDLE);
    assign arready = (state == IDLE) && !awvalid;
    assign wready  = (state == W_DATA);
    assign bvalid  = (state == W_RESP);
    assign rvalid  = (state == R_RESP);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        err_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (awvalid) begin
                    state_nxt = W_DATA;
                end else if (arvalid) begin
                    state_nxt = ar_bad ? R_RESP : R_REQ;
                    err_inc   = ar_bad;
                end
            end
            W_DATA: begin
                if (wvalid) begin
                    state_nxt = id_bad ? W_RESP : W_REQ;
                    err_inc   = id_bad;
                end
            end
            W_REQ: begin
                if (wack_hit || timeout) state_nxt = W_RESP;
                err_inc = timeout;
            end
            R_REQ: begin
                if (rack_hit || timeout) state_nxt = R_RESP;
                err_inc = timeout;
            end
            W_RESP:  if (bready) state_nxt = IDLE;
            R_RESP:  if (rready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // rdata is only written on the way into R_RESP, so it holds while rvalid is up.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            id        <= '0;
            reg_waddr <= '0;
            reg_raddr <= '0;
            reg_wdata <= '0;
            rdata     <= '0;
        end else begin
            if (state == IDLE && awvalid) begin
                id        <= awaddr[15:8];
                reg_waddr <= awaddr[7:0];
            end else if (state == IDLE && arvalid) begin
                id        <= araddr[15:8];
                reg_raddr <= araddr[7:0];
                if (ar_bad) rdata <= 32'hDEAD_00FF;
            end
            if (state == W_DATA && wvalid) reg_wdata <= wdata;
            if (state == R_REQ) begin
                if (rack_hit)     rdata <= sel_rdata;
                else if (timeout) rdata <= 32'hDEAD_0000 | {24'h0, id};
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt  <= '0;
            err_count <= '0;
        end else begin
            if ((state_nxt == W_REQ && state != W_REQ) || (state_nxt == R_REQ && state != R_REQ))
                wait_cnt <= '0;
            else if (waiting)
                wait_cnt <= wait_cnt + 16'd1;
            if (err_inc && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_ocl_tile_slave.sv
// Directed bench for ocl_tile_slave with default parameters (8 clients, TIMEOUT 255).
module tb_ocl_tile_slave;

    logic             clk = 1'b0;
    logic             rstn;
    logic             awvalid, awready, wvalid, wready, bvalid, bready;
    logic             arvalid, arready, rvalid, rready;
    logic [31:0]      awaddr, wdata, araddr, rdata;
    logic [7:0]       reg_wvalid, reg_wack, reg_rvalid, reg_rack;
    logic [7:0]       reg_waddr, reg_raddr;
    logic [31:0]      reg_wdata;
    logic [7:0][31:0] reg_rdata;
    logic [15:0]      err_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ocl_tile_slave #(.N_CLIENTS(8), .TIMEOUT(255)) dut (
        .clk(clk), .rstn(rstn),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .bvalid(bvalid), .bready(bready),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .reg_wvalid(reg_wvalid), .reg_wack(reg_wack), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .reg_rvalid(reg_rvalid), .reg_rack(reg_rack), .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
        .err_count(err_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = 0; wdata = 0; araddr = 0; reg_wack = 0; reg_rack = 0;
        for (int i = 0; i < 8; i++) reg_rdata[i] = 32'hBBBB_0000 + 32'(i);
        tick(); tick();
        checks++;
        if ({awready, arready, wready, bvalid, rvalid} !== 5'b11000) begin
            errors++; $display("[TB] FAIL reset_handshake got=%b exp=11000", {awready, arready, wready, bvalid, rvalid});
        end
        checks++;
        if (rdata !== 32'h0 || err_count !== 16'h0 || reg_wvalid !== 8'h0 || reg_rvalid !== 8'h0) begin
            errors++; $display("[TB] FAIL reset_data rdata=%h err=%h wv=%b rv=%b exp all zero", rdata, err_count, reg_wvalid, reg_rvalid);
        end
        checks++;
        if (reg_waddr !== 8'h0 || reg_raddr !== 8'h0 || reg_wdata !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_regs waddr=%h raddr=%h wdata=%h exp 0", reg_waddr, reg_raddr, reg_wdata);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_write();
        awvalid = 1; awaddr = 32'h0000_0312;
        #1;
        checks++;
        if (awready !== 1'b1) begin errors++; $display("[TB] FAIL wr_awready got=%b exp=1", awready); end
        tick();
        awvalid = 0;
        checks++;
        if (wready !== 1'b1) begin errors++; $display("[TB] FAIL wr_wready got=%b exp=1", wready); end
        wvalid = 1; wdata = 32'h0000_CAFE;
        tick();
        wvalid = 0;
        checks++;
        if (reg_wvalid !== 8'b0000_1000 || reg_waddr !== 8'h12 || reg_wdata !== 32'h0000_CAFE) begin
            errors++; $display("[TB] FAIL wr_req wv=%b waddr=%h wdata=%h exp 00001000/12/0000cafe", reg_wvalid, reg_waddr, reg_wdata);
        end
        reg_wack = 8'b0001_0000;
        tick();
        reg_wack = 0;
        tick();
        checks++;
        if (reg_wvalid !== 8'b0000_1000 || bvalid !== 1'b0) begin
            errors++; $display("[TB] FAIL wr_wrong_ack wv=%b bvalid=%b exp 00001000/0", reg_wvalid, bvalid);
        end
        reg_wack = 8'b0000_1000;
        tick();
        reg_wack = 0;
        checks++;
        if (bvalid !== 1'b1 || reg_wvalid !== 8'h0) begin
            errors++; $display("[TB] FAIL wr_bvalid bvalid=%b wv=%b exp 1/0", bvalid, reg_wvalid);
        end
        tick();
        checks++;
        if (bvalid !== 1'b1) begin errors++; $display("[TB] FAIL wr_bvalid_hold got=%b exp=1", bvalid); end
        bready = 1;
        tick();
        bready = 0;
        checks++;
        if (bvalid !== 1'b0 || err_count !== 16'd0 || awready !== 1'b1) begin
            errors++; $display("[TB] FAIL wr_done bvalid=%b err=%0d awready=%b exp 0/0/1", bvalid, err_count, awready);
        end
    endtask

    task automatic test_read();
        arvalid = 1; araddr = 32'h0000_0540;
        #1;
        checks++;
        if (arready !== 1'b1) begin errors++; $display("[TB] FAIL rd_arready got=%b exp=1", arready); end
        tick();
        arvalid = 0;
        checks++;
        if (reg_rvalid !== 8'b0010_0000 || reg_raddr !== 8'h40) begin
            errors++; $display("[TB] FAIL rd_req rv=%b raddr=%h exp 00100000/40", reg_rvalid, reg_raddr);
        end
        reg_rdata[5] = 32'h0000_1234; reg_rack = 8'b0010_0000;
        tick();
        reg_rack = 0; reg_rdata[5] = 32'h9999_9999;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rvalid !== 1'b1 || rdata !== 32'h0000_1234) begin
                errors++; $display("[TB] FAIL rd_hold%0d rvalid=%b rdata=%h exp 1/00001234", i, rvalid, rdata);
            end
            tick();
        end
        rready = 1;
        tick();
        rready = 0;
        checks++;
        if (rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rd_done rvalid=%b exp=0", rvalid); end
    endtask

    task automatic test_timeout();
        int cnt;
        arvalid = 1; araddr = 32'h0000_0200;
        tick();
        arvalid = 0;
        cnt = 0;
        while (reg_rvalid === 8'b0000_0100 && cnt < 1000) begin
            cnt++;
            tick();
        end
        checks++;
        if (cnt != 255) begin errors++; $display("[TB] FAIL to_wait_cycles got=%0d exp=255", cnt); end
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'hDEAD_0002 || err_count !== 16'd1) begin
            errors++; $display("[TB] FAIL to_resp rvalid=%b rdata=%h err=%0d exp 1/dead0002/1", rvalid, rdata, err_count);
        end
        rready = 1; tick(); rready = 0;
    endtask

    task automatic test_ack_at_limit();
        arvalid = 1; araddr = 32'h0000_0104;
        tick();
        arvalid = 0;
        reg_rdata[1] = 32'h5A5A_0101;
        for (int i = 0; i < 254; i++) tick();
        checks++;
        if (reg_rvalid !== 8'b0000_0010) begin errors++; $display("[TB] FAIL lim_still_req rv=%b exp=00000010", reg_rvalid); end
        reg_rack = 8'b0000_0010;
        tick();
        reg_rack = 0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'h5A5A_0101 || err_count !== 16'd1) begin
            errors++; $display("[TB] FAIL lim_ack_wins rvalid=%b rdata=%h err=%0d exp 1/5a5a0101/1", rvalid, rdata, err_count);
        end
        rready = 1; tick(); rready = 0;
    endtask

    task automatic test_bad_id();
        awvalid = 1; awaddr = 32'h0000_2000;
        tick();
        awvalid = 0; wvalid = 1; wdata = 32'h1111_2222;
        tick();
        wvalid = 0;
        checks++;
        if (bvalid !== 1'b1 || reg_wvalid !== 8'h0 || err_count !== 16'd2) begin
            errors++; $display("[TB] FAIL bad_wr bvalid=%b wv=%b err=%0d exp 1/0/2", bvalid, reg_wvalid, err_count);
        end
        bready = 1; tick(); bready = 0;
        arvalid = 1; araddr = 32'h0000_0900;
        tick();
        arvalid = 0;
        checks++;
        if (rvalid !== 1'b1 || reg_rvalid !== 8'h0 || rdata !== 32'hDEAD_00FF || err_count !== 16'd3) begin
            errors++; $display("[TB] FAIL bad_rd rvalid=%b rv=%b rdata=%h err=%0d exp 1/0/dead00ff/3", rvalid, reg_rvalid, rdata, err_count);
        end
        rready = 1; tick(); rready = 0;
    endtask

    task automatic test_back_to_back();
        awvalid = 1; awaddr = 32'h0000_0101; arvalid = 1; araddr = 32'h0000_0410;
        #1;
        checks++;
        if (awready !== 1'b1 || arready !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_arb awready=%b arready=%b exp 1/0", awready, arready);
        end
        tick();
        awvalid = 0; wvalid = 1; wdata = 32'h0000_00AA;
        tick();
        wvalid = 0;
        checks++;
        if (reg_wvalid !== 8'b0000_0010 || reg_rvalid !== 8'h0 || arready !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_wreq wv=%b rv=%b arready=%b exp 00000010/0/0", reg_wvalid, reg_rvalid, arready);
        end
        reg_wack = 8'b0000_0010;
        tick();
        reg_wack = 0;
        checks++;
        if (bvalid !== 1'b1 || arready !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_bresp bvalid=%b arready=%b exp 1/0", bvalid, arready);
        end
        bready = 1; tick(); bready = 0;
        checks++;
        if (arready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_arready got=%b exp=1", arready); end
        tick();
        arvalid = 0;
        checks++;
        if (reg_rvalid !== 8'b0001_0000 || reg_raddr !== 8'h10) begin
            errors++; $display("[TB] FAIL b2b_rreq rv=%b raddr=%h exp 00010000/10", reg_rvalid, reg_raddr);
        end
        reg_rdata[4] = 32'hFEED_0004; reg_rack = 8'b0001_0000;
        tick();
        reg_rack = 0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'hFEED_0004) begin
            errors++; $display("[TB] FAIL b2b_rdata rvalid=%b rdata=%h exp 1/feed0004", rvalid, rdata);
        end
        rready = 1; tick(); rready = 0;
    endtask

    task automatic test_reset_mid();
        arvalid = 1; araddr = 32'h0000_0600;
        tick();
        arvalid = 0;
        checks++;
        if (reg_rvalid !== 8'b0100_0000) begin errors++; $display("[TB] FAIL rst_mid_req rv=%b exp=01000000", reg_rvalid); end
        #1 rstn = 1'b0;
        #1;
        checks++;
        if (reg_rvalid !== 8'h0 || rvalid !== 1'b0 || rdata !== 32'h0 || err_count !== 16'h0 || awready !== 1'b1 || reg_raddr !== 8'h0) begin
            errors++; $display("[TB] FAIL rst_mid_async rv=%b rvalid=%b rdata=%h err=%0d awready=%b raddr=%h", reg_rvalid, rvalid, rdata, err_count, awready, reg_raddr);
        end
        #1 rstn = 1'b1;
        reg_rack = 8'b0100_0000;
        tick();
        reg_rack = 0;
        checks++;
        if (rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_no_rvalid got=%b exp=0", rvalid); end
        awvalid = 1; awaddr = 32'h0000_0007;
        tick();
        awvalid = 0; wvalid = 1; wdata = 32'h0BAD_F00D;
        tick();
        wvalid = 0;
        checks++;
        if (reg_wvalid !== 8'b0000_0001 || reg_waddr !== 8'h07 || reg_wdata !== 32'h0BAD_F00D) begin
            errors++; $display("[TB] FAIL rst_mid_wr wv=%b waddr=%h wdata=%h exp 00000001/07/0badf00d", reg_wvalid, reg_waddr, reg_wdata);
        end
        reg_wack = 8'b0000_0001;
        tick();
        reg_wack = 0;
        checks++;
        if (bvalid !== 1'b1 || err_count !== 16'd0) begin
            errors++; $display("[TB] FAIL rst_mid_bresp bvalid=%b err=%0d exp 1/0", bvalid, err_count);
        end
        bready = 1; tick(); bready = 0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_ack_at_limit();
        test_bad_id();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
